// File: rtl/frequency_analyzer_pkg.sv
// Shared types/constants for the frequency analyzer register map and results reader.
// Register indices match the analyzer manager's AXI slave layout.
package frequency_analyzer_pkg;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA,
        RD_PUSH,
        RD_FINISH
    } reader_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [7:0] PIXEL0_F0 = 8'd0;
    localparam logic [7:0] PIXEL0_F1 = 8'd1;
    localparam logic [7:0] PIXEL1_F0 = 8'd2;
    localparam logic [7:0] PIXEL1_F1 = 8'd3;
    localparam logic [7:0] PIXEL2_F0 = 8'd4;
    localparam logic [7:0] PIXEL2_F1 = 8'd5;

    // Anything other than OKAY (including EXOKAY) is treated as a failed read.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_read_channel.sv
// Single-read AXI4-Lite AR/R handshake for the results reader.
// Optional per-handshake watchdog when READ_TIMEOUT_EN is defined.
module axi_lite_read_channel
    import frequency_analyzer_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  addr_req,
    input  logic                  data_req,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic [1:0]            resp,
    output logic                  addr_done,
    output logic                  complete,
    output logic                  timed_out,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    // Address is gated so the bus shows zero whenever no request is live.
    assign arvalid   = addr_req;
    assign araddr    = addr_req ? addr : '0;
    assign arprot    = 3'b000;
    assign rready    = data_req;
    assign addr_done = addr_req & arready;
    assign complete  = data_req & rvalid;
    assign data      = rdata;
    assign resp      = rresp;

`ifdef READ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;
    logic          active;
    logic          handshake;

    assign active    = addr_req | data_req;
    assign handshake = addr_done | complete;
    assign timed_out = active && !handshake &&
                       (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Restarts on every handshake so ADDR and DATA each get a full budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!active || handshake || timed_out) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^{TIMEOUT_CYCLES, clk, rst_n};
    assign timed_out      = 1'b0;
`endif

endmodule

// File: rtl/frequency_results_reader.sv
// Sweeps the analyzer result registers over AXI4-Lite on each trigger edge and
// streams them out; READ_TIMEOUT_EN adds a per-handshake watchdog.
module frequency_results_reader
    import frequency_analyzer_pkg::*;
#(
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int C_M00_AXI_ADDR_WIDTH = 10,
    parameter int BASE_ADDRESS         = 0,
    parameter int NUMBER_OF_REGISTERS  = 6,
    parameter int REGISTER_STRIDE      = 4,
    parameter int TIMEOUT_CYCLES       = 1024
) (
    input  logic                            m00_axi_aclk,
    input  logic                            m00_axi_aresetn,
    input  logic                            trigger,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [C_M00_AXI_DATA_WIDTH-1:0] result_data,
    output logic [7:0]                      result_index,
    output logic                            result_last,
    output logic                            result_valid,
    input  logic                            result_ready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic [2:0]                      m00_axi_arprot,
    output logic                            m00_axi_arvalid,
    input  logic                            m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
    input  logic [1:0]                      m00_axi_rresp,
    input  logic                            m00_axi_rvalid,
    output logic                            m00_axi_rready
);

    localparam int AW = C_M00_AXI_ADDR_WIDTH;
    localparam int DW = C_M00_AXI_DATA_WIDTH;

    reader_state_t state;
    reader_state_t next_state;

    logic          trig_q;
    logic          trig_d;
    logic          trig_edge;
    logic [7:0]    index;
    logic          is_last;
    logic [AW-1:0] reg_addr;

    logic [DW-1:0] rd_data;
    logic [1:0]    rd_resp;
    logic          rd_addr_done;
    logic          rd_complete;
    logic          rd_timed_out;

    assign trig_edge = trig_q & ~trig_d;
    assign is_last   = (index == 8'(NUMBER_OF_REGISTERS - 1));

    // Computed at address width so the result wraps like the bus does.
    assign reg_addr = AW'(BASE_ADDRESS) + AW'(index) * AW'(REGISTER_STRIDE);

    axi_lite_read_channel #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_read_channel (
        .clk       (m00_axi_aclk),
        .rst_n     (m00_axi_aresetn),
        .addr_req  (state == RD_ADDR),
        .data_req  (state == RD_DATA),
        .addr      (reg_addr),
        .data      (rd_data),
        .resp      (rd_resp),
        .addr_done (rd_addr_done),
        .complete  (rd_complete),
        .timed_out (rd_timed_out),
        .araddr    (m00_axi_araddr),
        .arprot    (m00_axi_arprot),
        .arvalid   (m00_axi_arvalid),
        .arready   (m00_axi_arready),
        .rdata     (m00_axi_rdata),
        .rresp     (m00_axi_rresp),
        .rvalid    (m00_axi_rvalid),
        .rready    (m00_axi_rready)
    );

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state <= RD_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            RD_IDLE: begin
                if (trig_edge) next_state = RD_ADDR;
            end
            RD_ADDR: begin
                if (rd_timed_out)      next_state = RD_FINISH;
                else if (rd_addr_done) next_state = RD_DATA;
            end
            RD_DATA: begin
                if (rd_timed_out)     next_state = RD_FINISH;
                else if (rd_complete) next_state = RD_PUSH;
            end
            RD_PUSH: begin
                if (result_ready) next_state = is_last ? RD_FINISH : RD_ADDR;
            end
            RD_FINISH: begin
                next_state = RD_IDLE;
            end
            default: begin
                next_state = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            trig_q      <= 1'b0;
            trig_d      <= 1'b0;
            index       <= '0;
            result_data <= '0;
            error       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            trig_q <= trigger;
            trig_d <= trig_q;
            if (state == RD_IDLE && trig_edge) begin
                error <= 1'b0;
                index <= '0;
                busy  <= 1'b1;
            end
            // Errored reads are still forwarded; only the sticky flag records them.
            if (state == RD_DATA && rd_complete) begin
                result_data <= rd_data;
                if (resp_is_error(rd_resp)) error <= 1'b1;
            end
            if (rd_timed_out) begin
                error <= 1'b1;
            end
            if (state == RD_PUSH && result_ready && !is_last) begin
                index <= index + 8'd1;
            end
            if (state == RD_FINISH) begin
                busy <= 1'b0;
            end
        end
    end

    assign done         = (state == RD_FINISH);
    assign result_valid = (state == RD_PUSH);
    assign result_last  = (state == RD_PUSH) && is_last;
    assign result_index = index;

endmodule

// File: tb/tb_frequency_results_reader.sv
// Randomized bench for frequency_results_reader against a register-table model
// and a behavioural AXI4-Lite slave.
module tb_frequency_results_reader;
    import frequency_analyzer_pkg::*;

    localparam int N  = 6;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          trigger = 1'b0;
    logic          busy, done, error;
    logic [31:0]   result_data;
    logic [7:0]    result_index;
    logic          result_last, result_valid;
    logic          result_ready = 1'b0;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [31:0]   rdata = '0;
    logic [1:0]    rresp = '0;
    logic          rvalid = 1'b0;
    logic          rready;

    always #5 clk = ~clk;

    frequency_results_reader #(
        .C_M00_AXI_DATA_WIDTH (32),
        .C_M00_AXI_ADDR_WIDTH (AW),
        .BASE_ADDRESS         (0),
        .NUMBER_OF_REGISTERS  (N),
        .REGISTER_STRIDE      (4),
        .TIMEOUT_CYCLES       (16)
    ) dut (
        .m00_axi_aclk    (clk),
        .m00_axi_aresetn (rst_n),
        .trigger         (trigger),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .result_data     (result_data),
        .result_index    (result_index),
        .result_last     (result_last),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .m00_axi_araddr  (araddr),
        .m00_axi_arprot  (arprot),
        .m00_axi_arvalid (arvalid),
        .m00_axi_arready (arready),
        .m00_axi_rdata   (rdata),
        .m00_axi_rresp   (rresp),
        .m00_axi_rvalid  (rvalid),
        .m00_axi_rready  (rready)
    );

    typedef struct {
        logic [31:0] data;
        int          index;
        bit          last;
    } beat_t;

    // Register file seen by the slave, and the reference for expected beats.
    logic [31:0] mem [256];
    logic [1:0]  rresp_tbl [256];
    int          ar_wait [256];
    int          r_delay [256];
    bit          r_never [256];

    beat_t beats[$];
    int    addr_log[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cnt = 0;

    int viol_ar_stable = 0;
    int viol_both      = 0;
    int viol_frozen    = 0;
    int viol_stall_ar  = 0;
    int stall_obs      = 0;

    int stall_at    = -1;
    int stall_len   = 0;
    bit stall_started = 0;
    bit rand_ready  = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
    end

    // AXI4-Lite slave: one read at a time, per-register wait states.
    initial begin
        bit          pend = 0;
        bit          ar_seen = 0;
        logic [AW-1:0] ar_addr = '0;
        int          ar_cnt = 0;
        int          r_cnt = 0;
        int          idx = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                arready = 0; rvalid = 0; pend = 0; ar_seen = 0;
                continue;
            end
            if (arvalid && rready) viol_both++;
            if (rvalid) begin
                rvalid = 0;
                pend = 0;
            end
            if (arready) begin
                arready = 0;
                addr_log.push_back(int'(ar_addr));
                idx = int'(ar_addr) >> 2;
                pend = 1;
                r_cnt = 0;
                ar_seen = 0;
            end else if (arvalid) begin
                if (ar_seen && araddr !== ar_addr) viol_ar_stable++;
                if (!ar_seen) begin
                    ar_seen = 1;
                    ar_addr = araddr;
                    ar_cnt = 0;
                end
                if (ar_cnt >= ar_wait[int'(ar_addr) >> 2]) arready = 1;
                else ar_cnt++;
            end
            if (pend && !rvalid && rready && !r_never[idx]) begin
                if (r_cnt >= r_delay[idx]) begin
                    rvalid = 1;
                    rdata = mem[idx];
                    rresp = rresp_tbl[idx];
                end else begin
                    r_cnt++;
                end
            end
        end
    end

    // Result sink: drives ready, records beats, watches stalled beats.
    initial begin
        bit          last_valid = 0;
        bit          stalled;
        int          stall_left = 0;
        logic [31:0] held_data = '0;
        logic [7:0]  held_index = '0;
        beat_t       b;
        forever begin
            @(negedge clk);
            stalled = last_valid && !result_ready;
            if (stalled && result_valid) begin
                stall_obs++;
                if (result_data !== held_data || result_index !== held_index)
                    viol_frozen++;
                if (arvalid) viol_stall_ar++;
            end
            if (result_valid && stall_at >= 0 &&
                int'(result_index) == stall_at && !stall_started) begin
                stall_started = 1;
                stall_left = stall_len;
            end
            if (stall_left > 0) begin
                result_ready = 0;
                stall_left--;
            end else if (rand_ready) begin
                result_ready = ($urandom_range(0, 99) < 60);
            end else begin
                result_ready = 1;
            end
            if (result_valid && result_ready && rst_n) begin
                b.data = result_data;
                b.index = int'(result_index);
                b.last = result_last;
                beats.push_back(b);
            end
            last_valid = result_valid && rst_n;
            held_data = result_data;
            held_index = result_index;
        end
    end

    function automatic bit exp_error();
        for (int i = 0; i < N; i++)
            if (rresp_tbl[i] != RESP_OKAY) return 1;
        return 0;
    endfunction

    task automatic arm_trigger(output int t0);
        @(negedge clk);
        trigger = 0;
        @(negedge clk);
        @(negedge clk);
        trigger = 1;
        t0 = cyc;
    endtask

    task automatic expect_sweep(input string tag, input bit chk_lat,
                                input bit toggle);
        int d0, t0, done_at;
        bit seen_busy, got_done;
        beats.delete();
        addr_log.delete();
        d0 = done_cnt;
        done_at = 0;
        seen_busy = 0;
        got_done = 0;
        arm_trigger(t0);
        for (int k = 0; k < 3000 && !got_done; k++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1;
                done_at = cyc;
                trigger = 0;
                check({tag, "_err"}, error, exp_error());
            end else begin
                if (busy && !seen_busy) begin
                    seen_busy = 1;
                    check({tag, "_errclr"}, error, 0);
                end
                if (toggle && busy && (k % 2 == 0)) trigger = ~trigger;
            end
        end
        check({tag, "_done"}, got_done, 1);
        if (chk_lat) check({tag, "_lat"}, done_at - t0 - 1, 3 * N + 1);
        repeat (20) @(negedge clk);
        check({tag, "_ndone"}, done_cnt - d0, 1);
        check({tag, "_nbeats"}, beats.size(), N);
        check({tag, "_naddr"}, addr_log.size(), N);
        for (int i = 0; i < N; i++) begin
            if (i < beats.size()) begin
                check({tag, "_data"}, beats[i].data, mem[i]);
                check({tag, "_idx"}, beats[i].index, i);
                check({tag, "_last"}, beats[i].last, (i == N - 1));
            end
            if (i < addr_log.size())
                check({tag, "_addr"}, addr_log[i], 4 * i);
        end
    endtask

    function automatic logic [63:0] outs();
        return {busy, done, error, result_valid, result_last, result_index,
                result_data, arvalid, araddr, rready, arprot};
    endfunction

    initial begin
        int t0, d0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'(200 + i);
            rresp_tbl[i] = RESP_OKAY;
            ar_wait[i] = 0;
            r_delay[i] = 0;
            r_never[i] = 0;
        end

        #12;
        check("reset_outs", outs(), 0);
        @(negedge clk);
        #2 rst_n = 1;

        expect_sweep("zero_wait", 1, 0);

        ar_wait[2] = 7;
        viol_ar_stable = 0;
        expect_sweep("ar_wait", 0, 0);
        check("ar_stable", viol_ar_stable, 0);
        ar_wait[2] = 0;

        stall_at = 3;
        stall_len = 10;
        stall_started = 0;
        stall_obs = 0;
        viol_frozen = 0;
        viol_stall_ar = 0;
        expect_sweep("stall", 0, 0);
        check("stall_cycles", stall_obs, 10);
        check("stall_frozen", viol_frozen, 0);
        check("stall_no_ar", viol_stall_ar, 0);
        stall_at = -1;

        rresp_tbl[4] = RESP_SLVERR;
        expect_sweep("slverr", 0, 0);
        rresp_tbl[4] = RESP_OKAY;
        expect_sweep("err_clear", 0, 0);

        expect_sweep("toggle", 1, 1);

        // Reset in the middle of a sweep.
        beats.delete();
        arm_trigger(t0);
        for (int k = 0; k < 300 && beats.size() < 2; k++) @(negedge clk);
        check("rst_reach_beat2", beats.size() >= 2, 1);
        d0 = done_cnt;
        #2 rst_n = 0;
        #1 check("rst_mid_outs", outs(), 0);
        trigger = 0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1;
        repeat (30) @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_idle", busy, 0);
        expect_sweep("restart", 1, 0);

        rand_ready = 1;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < N; i++) begin
                mem[i] = $urandom;
                ar_wait[i] = $urandom_range(0, 3);
                r_delay[i] = $urandom_range(0, 3);
                if ($urandom_range(0, 9) == 0)
                    rresp_tbl[i] = $urandom_range(0, 1) ? RESP_SLVERR : RESP_DECERR;
                else
                    rresp_tbl[i] = RESP_OKAY;
            end
            expect_sweep("random", 0, 0);
        end
        rand_ready = 0;
        for (int i = 0; i < N; i++) begin
            ar_wait[i] = 0;
            r_delay[i] = 0;
            rresp_tbl[i] = RESP_OKAY;
        end

`ifdef READ_TIMEOUT_EN
        begin
            bit got_done;
            bit err_seen;
            r_never[1] = 1;
            beats.delete();
            d0 = done_cnt;
            got_done = 0;
            err_seen = 0;
            arm_trigger(t0);
            for (int k = 0; k < 500 && !got_done; k++) begin
                @(negedge clk);
                if (done) begin
                    got_done = 1;
                    err_seen = error;
                    trigger = 0;
                end
            end
            check("to_done", got_done, 1);
            check("to_err", err_seen, 1);
            repeat (20) @(negedge clk);
            check("to_ndone", done_cnt - d0, 1);
            check("to_nbeats", beats.size(), 1);
            if (beats.size() > 0) check("to_beat0", beats[0].data, mem[0]);
            r_never[1] = 0;
            @(negedge clk);
            #2 rst_n = 0;
            @(negedge clk);
            #2 rst_n = 1;
        end
`endif

        check("ar_r_exclusive", viol_both, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/frequency_results_reader.md
Name: frequency_results_reader

Overview:
- AXI4-Lite read master; the other end of the register interface exposed by the frequency analyzer manager's AXI slave.
- On the analyzer's irq (stop) edge, reads NUMBER_OF_REGISTERS consecutive 32-bit result registers: pixel0..2 f0/f1 action times.
- Emits each register as one beat on a valid/ready result stream to downstream logic (e.g. a DMA packer or debug UART).
- Sits in the s00_axi_aclk domain, beside the analyzer, on the same interconnect.

Parameters:
- C_M00_AXI_DATA_WIDTH, 32: read data width; only 32 supported.
- C_M00_AXI_ADDR_WIDTH, 10: address width.
- BASE_ADDRESS, 0: byte address of register 0.
- NUMBER_OF_REGISTERS, 6: registers per burst of reads, range 1..255.
- REGISTER_STRIDE, 4: byte distance between registers.
- TIMEOUT_CYCLES, 1024: cycles allowed per channel handshake (used only with READ_TIMEOUT_EN).

Ports:
- m00_axi_aclk  in  1  clock
- m00_axi_aresetn  in  1  asynchronous active-low reset
- trigger  in  1  level input (analyzer irq); a rising edge starts a read sweep
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end
- error  out  1  sticky; set on SLVERR/DECERR or timeout; cleared by the next accepted trigger
- result_data  out  32  register value
- result_index  out  8  register number, 0-based
- result_last  out  1  high with the final beat
- result_valid  out  1  stream valid
- result_ready  in  1  stream ready
- m00_axi_araddr  out  C_M00_AXI_ADDR_WIDTH  read address
- m00_axi_arprot  out  3  constant 3'b000
- m00_axi_arvalid  out  1  address valid
- m00_axi_arready  in  1  address ready
- m00_axi_rdata  in  32  read data
- m00_axi_rresp  in  2  read response
- m00_axi_rvalid  in  1  read valid
- m00_axi_rready  out  1  read ready

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; index 0; trigger edge register 0.
- Trigger: registered; a rising edge is detected only in IDLE. Edges while busy are ignored and not queued.
- FSM: IDLE -> ADDR -> DATA -> PUSH -> (ADDR with index+1 | FINISH) -> IDLE.
- IDLE, on trigger edge:
  - clear error and index;
  - busy <= 1;
  - go to ADDR.
- ADDR:
  - arvalid = 1; araddr = BASE_ADDRESS + index*REGISTER_STRIDE, truncated to the address width.
  - arvalid and araddr stay stable until arready. On arvalid & arready, drop arvalid and go to DATA.
- DATA:
  - rready = 1. On rvalid, latch rdata into result_data and go to PUSH.
  - rresp != 2'b00 sets error; the data is still forwarded.
- PUSH:
  - result_valid = 1; result_index = index; result_last = (index == NUMBER_OF_REGISTERS-1).
  - Data is held stable until result_ready. On the handshake, if last go to FINISH, else index+1 and go to ADDR.
- FINISH: done pulses for 1 cycle; busy <= 0; go to IDLE.
- Only one outstanding read at a time; AR and R are never both asserted by this block in the same cycle.
- Minimum latency per register: 3 cycles with arready and rvalid zero-wait and result_ready held high.
- Back-pressure: result_ready low stalls in PUSH indefinitely. No AXI request is issued meanwhile.
- Reset mid-sweep: asynchronous return to IDLE and all outputs 0. A partial sweep is discarded, with no done pulse.

Optional Feature:
- Macro READ_TIMEOUT_EN.
- Defined:
  - a counter runs in ADDR and DATA and reloads on entry to each;
  - if it reaches TIMEOUT_CYCLES without the handshake, set error, deassert arvalid/rready and go to FINISH;
  - no further beats are sent, and done still pulses.
- Undefined: no counter; ADDR and DATA wait forever.

Decomposition:
- Shared package frequency_analyzer_pkg holds:
  - FSM state enum for this block;
  - AXI response constants (OKAY=0, SLVERR=2, DECERR=3);
  - register index constants 0..5 (PIXEL0_F0..PIXEL2_F1), shared with the analyzer manager.
- One natural sub-module: axi_lite_read_channel, which owns the ADDR/DATA handshake and the optional timeout. It returns data, resp and a completion pulse for a given address. The top keeps the sweep counter and the result stream.

Test Plan:
- Zero-wait slave returning 200+index, result_ready=1, trigger edge -> 6 beats with data 200..205 and index 0..5; araddr 0,4,..,20; result_last only on beat 5; done 19 cycles after the edge; error=0.
- Slave holds arready low for 7 cycles on register 2 -> araddr=8 stays stable throughout; beat sequence unchanged.
- result_ready low for 10 cycles at beat 3 -> result_data/result_index stay frozen; no arvalid asserted during the stall.
- rresp=SLVERR on register 4 -> beat 4 still delivered, error=1 at done; the next trigger edge clears error.
- Trigger toggled while busy, then m00_axi_aresetn pulsed low at beat 2 -> toggle ignored; on reset all outputs 0 immediately, no done; a later trigger restarts from index 0.
- READ_TIMEOUT_EN, TIMEOUT_CYCLES=16, rvalid never asserted on register 1 -> error=1, done pulse, only beat 0 emitted.
